speed_div_ctrl: RTL and testbench

Parametrised successor to the fixed-step audio speed divider. It turns speed_up / speed_down / speed_reset requests into a saturating divisor register, and auto-repeats while a request is held. An integrated tick generator produces a one-cycle clock-enable every div_out cycles. It sits between the keyboard/button command decoder and the audio sample-rate logic, replacing the hand-built divider counter downstream.

---
 rtl/speed_div_pkg.sv | 16 +
 rtl/speed_div_ctrl_tick_gen.sv | 20 ++
 rtl/speed_div_ctrl.sv | 63 ++++++
 tb/tb_speed_div_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/speed_div_pkg.sv
// speed_div_pkg: command encoding and saturating divisor step helpers for speed_div_ctrl.
package speed_div_pkg;
    typedef enum logic [1:0] {CMD_NONE, CMD_UP, CMD_DOWN, CMD_RESET} cmd_t;
    localparam int MAX_W = 64;
    // Callers zero-extend their WIDTH-bit values into MAX_W and truncate the result.
    function automatic logic [MAX_W-1:0] sat_up(input logic [MAX_W-1:0] div, step, lo);
        logic [MAX_W:0] lim;
        lim = {1'b0, lo} + {1'b0, step};
        return ({1'b0, div} < lim) ? lo : div - step;
    endfunction
    function automatic logic [MAX_W-1:0] sat_down(input logic [MAX_W-1:0] div, step, hi);
        logic [MAX_W:0] sum;
        sum = {1'b0, div} + {1'b0, step};
        return (sum > {1'b0, hi}) ? hi : sum[MAX_W-1:0];
    endfunction
endpackage

// File: rtl/speed_div_ctrl_tick_gen.sv
// div_tick_gen: one-cycle tick every div cycles; a shrinking divisor ends the period at once.
module div_tick_gen import speed_div_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] div,
    output logic             tick
);
    logic [WIDTH-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= cnt >= div - WIDTH'(1);
            cnt  <= (cnt >= div - WIDTH'(1)) ? '0 : cnt + WIDTH'(1);
        end
    end
endmodule

// File: rtl/speed_div_ctrl.sv
// speed_div_ctrl: turns up/down/reset requests into a saturating divisor with auto-repeat,
// and drives a tick generator from it.
module speed_div_ctrl import speed_div_pkg::*; #(
    parameter int          WIDTH         = 32,
    parameter int unsigned DIV_DEFAULT   = 32'h470,
    parameter int unsigned STEP          = 16,
    parameter int unsigned DIV_MIN       = 16,
    parameter int unsigned DIV_MAX       = 32'h0000_FFFF,
    parameter int unsigned REPEAT_CYCLES = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             speed_up,
    input  logic             speed_down,
    input  logic             speed_reset,
    output logic [WIDTH-1:0] div_out,
    output logic             tick,
    output logic             at_min,
    output logic             at_max
);
    localparam logic [WIDTH-1:0] DEF      = WIDTH'(DIV_DEFAULT);
    localparam logic [WIDTH-1:0] LO       = WIDTH'(DIV_MIN);
    localparam logic [WIDTH-1:0] HI       = WIDTH'(DIV_MAX);
    localparam logic [WIDTH-1:0] RPT_LAST = WIDTH'(REPEAT_CYCLES - 1);
    localparam bit               RPT_EN   = REPEAT_CYCLES != 0;
    cmd_t             cmd, prev_cmd;
    logic             hist_ok, mover, same, rpt, fire;
    logic [WIDTH-1:0] hold, up_val, dn_val;
    always_comb begin
        cmd    = speed_reset ? CMD_RESET :
                 (speed_up ^ speed_down) ? (speed_up ? CMD_UP : CMD_DOWN) : CMD_NONE;
        mover  = cmd == CMD_UP || cmd == CMD_DOWN;
        same   = hist_ok && cmd == prev_cmd;
        rpt    = RPT_EN && mover && same && hold == RPT_LAST;
        // A request already held when reset releases has no history, so it is not an edge.
        fire   = rpt || (mover && hist_ok && !same);
        up_val = WIDTH'(sat_up(MAX_W'(div_out), MAX_W'(STEP), MAX_W'(DIV_MIN)));
        dn_val = WIDTH'(sat_down(MAX_W'(div_out), MAX_W'(STEP), MAX_W'(DIV_MAX)));
        at_min = div_out == LO;
        at_max = div_out == HI;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_out  <= DEF;
            hold     <= '0;
            prev_cmd <= CMD_NONE;
            hist_ok  <= 1'b0;
        end else begin
            prev_cmd <= cmd;
            hist_ok  <= 1'b1;
            hold     <= (!mover || !same || rpt) ? '0 : hold + WIDTH'(1);
            div_out  <= cmd == CMD_RESET ? DEF :
                        !fire ? div_out :
                        cmd == CMD_UP ? up_val : dn_val;
        end
    end
    div_tick_gen #(.WIDTH(WIDTH)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .div  (div_out),
        .tick (tick)
    );
endmodule

// File: tb/tb_speed_div_ctrl.sv
// tb_speed_div_ctrl: directed stimulus, per-cycle check against a behavioural model,
// plus literal expectations at key points.
module tb_speed_div_ctrl;
    localparam int W = 8, DEF = 20, ST = 4, MN = 8, MX = 32, RC = 10;
    logic clk = 0, rst_n = 0, su = 0, sd = 0, sr = 0;
    logic [W-1:0] div_out;
    logic tick, at_min, at_max;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    speed_div_ctrl #(.WIDTH(W), .DIV_DEFAULT(DEF), .STEP(ST), .DIV_MIN(MN), .DIV_MAX(MX),
                     .REPEAT_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .speed_up(su), .speed_down(sd), .speed_reset(sr),
        .div_out(div_out), .tick(tick), .at_min(at_min), .at_max(at_max));
    // m_run: cycles the current command has been continuously held; m_e: cycles into the tick period
    int m_div = DEF, m_prev = -1, m_run = 0, m_e = 0;
    bit m_tick = 0;
    always @(posedge clk or negedge rst_n) begin
        int c;
        if (!rst_n) begin
            m_div = DEF; m_prev = -1; m_run = 0; m_e = 0; m_tick = 0;
        end else begin
            c = sr ? 3 : (su ^ sd) ? (su ? 1 : 2) : 0;
            m_e++;
            m_tick = m_e >= m_div;
            if (m_tick) m_e = 0;
            if (c == 3) begin
                m_div = DEF; m_run = 0;
            end else begin
                if (c == m_prev) m_run++; else m_run = 0;
                if ((c == 1 || c == 2) &&
                    ((c != m_prev && m_prev != -1) || (c == m_prev && m_run % RC == 0)))
                    m_div = (c == 1) ? ((m_div - ST < MN) ? MN : m_div - ST)
                                     : ((m_div + ST > MX) ? MX : m_div + ST);
            end
            m_prev = c;
        end
    end
    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
        end
    endtask
    always @(negedge clk) begin
        chk("model_div", int'(div_out), m_div);
        chk("model_tick", int'(tick), int'(m_tick));
        chk("model_at_min", int'(at_min), int'(m_div == MN));
        chk("model_at_max", int'(at_max), int'(m_div == MX));
    end
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask
    initial begin
        bit found;
        step(3);
        chk("rst_div", div_out, 20);
        chk("rst_tick", tick, 0);
        chk("rst_flags", {at_min, at_max}, 0);
        rst_n = 1;
        step(19); chk("tick19", tick, 0);
        step(1);  chk("tick20", tick, 1);
        step(1);  chk("tick21", tick, 0);
        step(19); chk("tick40", tick, 1);
        step(20); chk("tick60", tick, 1);
        chk("idle_flags", {at_min, at_max}, 0);
        for (int i = 0; i < 4; i++) begin
            su = 1; step(1);
            chk("up_pulse", div_out, (i < 3) ? 16 - 4 * i : 8);
            su = 0; step(3);
        end
        chk("at_min", at_min, 1);
        sr = 1; step(1); chk("sr_to_def", div_out, 20); sr = 0;
        sd = 1; step(1); chk("down_k", div_out, 24);
        step(9);  chk("down_k9", div_out, 24);
        step(1);  chk("down_k10", div_out, 28);
        step(10); chk("down_k20", div_out, 32);
        chk("at_max", at_max, 1);
        step(19); chk("down_sat", div_out, 32);
        sd = 0;
        sr = 1; step(1); chk("sr_again", div_out, 20); sr = 0;
        su = 1; sd = 1; step(15); chk("both_held", div_out, 20);
        sd = 0; step(1); chk("up_after_both", div_out, 16);
        su = 0; step(5); chk("single_step", div_out, 16);
        sd = 1; step(31); chk("climb_32", div_out, 32); sd = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            found = tick;
        end
        chk("tick_wait", found, 1);
        step(25);
        sr = 1; step(1);
        chk("sr_cnt25_div", div_out, 20);
        chk("sr_cnt25_tick", tick, 0);
        sr = 0;
        step(1);  chk("sr_tick_next", tick, 1);
        step(19); chk("sr_tick_gap", tick, 0);
        step(1);  chk("sr_tick_20", tick, 1);
        sd = 1; step(1); chk("hold_24", div_out, 24);
        step(10); chk("hold_28", div_out, 28);
        step(3);
        rst_n = 0; #1;
        chk("async_div", div_out, 20);
        chk("async_tick", tick, 0);
        step(3);
        chk("in_rst_div", div_out, 20);
        chk("in_rst_tick", tick, 0);
        rst_n = 1;
        step(10); chk("no_step_after_rst", div_out, 20);
        sd = 0; step(2);
        sd = 1; step(1); chk("new_edge", div_out, 24);
        sd = 0; step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
